mult_sequencer: RTL and testbench
=================================

MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named `clk` and `rst`.
REQ-002 Ports SHALL be, in order (name, direction, width, meaning):
- `clk`, in, 1: clock.
- `rst`, in, 1: async active-high reset.
- `MultStartE`, in, 1: multiply request from the execute register.
- `MultSgnE`, in, 1: 1 = signed, 0 = unsigned.
- `FlushE`, in, 1: abort the in-flight multiply.
- `SrcAE`, in, 32: multiplicand.
- `SrcBE`, in, 32: multiplier.
- `ALUOut`, in, 32: shared ALU sum.
- `ALUSel`, out, 1: 1 = the sequencer owns the ALU operands and function.
- `ALU_A`, out, 32: ALU operand a.
- `ALU_B`, out, 32: ALU operand b.
- `ALUF`, out, 3: ALU function override.
- `hi`, out, 32: upper product word.
- `lo`, out, 32: lower product word.
- `StallMult`, out, 1: stall request to the hazard unit.
- `completed`, out, 1: one-cycle done pulse.

Function
REQ-003 The state machine SHALL have states IDLE, ITER, SIGN and DONE.
REQ-004 In IDLE, on a clock edge with `MultStartE`=1 and `FlushE`=0, the block SHALL:
- latch |SrcAE| into `mcand` and |SrcBE| into `mplier`, using magnitude only if `MultSgnE`=1, else raw;
- latch `neg` = `MultSgnE` & (SrcAE[31] ^ SrcBE[31]);
- clear the 64-bit accumulator {acc_hi, acc_lo};
- set count=0 and go to ITER.
REQ-005 `MultStartE` SHALL be ignored in ITER, SIGN and DONE.
REQ-006 Each ITER cycle SHALL perform the following:
- drive `ALU_A`=acc_hi, `ALU_B`=(mplier[0] ? mcand : 0), `ALUF`=3'b010 (add) and `ALUSel`=1;
- compute the carry locally as (a31&b31)|((a31|b31)&~ALUOut[31]);
- at the edge, shift {carry, ALUOut, acc_lo} right by 1 into {acc_hi, acc_lo}, shift `mplier` right by 1, and increment count.
REQ-007 After exactly 32 ITER cycles (count reaches 32), the block SHALL go to SIGN.
REQ-008 SIGN SHALL last one cycle, in which the block loads `hi`/`lo` with {acc_hi, acc_lo}, or its 64-bit two's complement if `neg`=1, and then goes to DONE. No ALU use occurs in SIGN.
REQ-009 DONE SHALL last one cycle, with `completed`=1, and then return to IDLE.
REQ-010 `completed` SHALL be high only in DONE.
REQ-011 `StallMult` SHALL be 1 in ITER and SIGN and 0 in IDLE and DONE.
REQ-012 Latency SHALL be 34 cycles: with the start sampled at edge N, `completed` is high in the cycle between edges N+33 and N+34.
REQ-013 Outside ITER, the ALU outputs SHALL be `ALUSel`=0, `ALU_A`=0, `ALU_B`=0 and `ALUF`=3'b000.
REQ-014 `hi`/`lo` SHALL change only in SIGN and on reset, and SHALL hold their value otherwise, including during a later multiply.
REQ-015 `FlushE`=1 in ITER or SIGN SHALL abort at that edge: the block returns to IDLE, `hi`/`lo` are unchanged, and no `completed` pulse is produced.
REQ-016 `FlushE`=1 in DONE SHALL NOT suppress the `completed` pulse of that cycle.
REQ-017 Boundary operands SHALL be handled as follows:
- signed -2^31 SHALL be treated as magnitude 2^31 (unsigned 32-bit);
- a zero operand with opposite signs SHALL yield 0, because the negation of 0 is 0.

Reset
REQ-018 Asserting `rst` SHALL immediately force the following, including mid-operation: state IDLE; `hi`, `lo`, `acc`, `mcand`, `mplier`, `count` and `neg` to 0; `ALUSel`, `StallMult` and `completed` to 0; `ALU_A`, `ALU_B` and `ALUF` to 0.
REQ-019 The first start SHALL be accepted on the first rising clock edge after `rst` deasserts.

Structure
REQ-020 A shared package SHALL hold the state enum (IDLE, ITER, SIGN, DONE), the ALU_ADD code 3'b010 and MULT_ITERS=32.
REQ-021 The block SHALL have no sub-module: the magnitude, negation and carry logic are inline; the ALU stays external and shared through `ALUSel`.

Verification
REQ-022 Unsigned multiply: 0xFFFFFFFF × 0xFFFFFFFF with `MultSgnE`=0 → `hi`=0xFFFFFFFE, `lo`=0x00000001, and `completed` exactly 33 edges after start.
REQ-023 Signed multiply: -3 × 7 with `MultSgnE`=1 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `StallMult` is high for 33 cycles and low while `completed`=1.
REQ-024 Signed boundary: 0x80000000 × 0x80000000 with `MultSgnE`=1 → `hi`=0x40000000, `lo`=0; the same operands with `MultSgnE`=0 → `hi`=0x40000000, `lo`=0.
REQ-025 Flush mid-operation: after a completed 5 × 6 (`lo`=30), start 9 × 9 and assert `FlushE` at ITER count 10 → IDLE next cycle, no `completed` pulse, `lo` stays 30.
REQ-026 Reset mid-operation: assert `rst` at ITER count 20 → all outputs 0 immediately; after release, 2 × 3 yields `lo`=6, `hi`=0.
REQ-027 ALU sharing: during ITER with `mplier[0]`=0, check `ALU_B`=0 and `ALUF`=3'b010; in IDLE, check `ALUSel`=0 and ignore a `MultStartE` pulse raised during ITER.

Source files
------------

// File: rtl/mult_sequencer_pkg.sv
// Shared types and constants for the shift-add multiply sequencer.
// The iteration counter is wide enough to hold MULT_ITERS itself.
package mult_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_NONE   = 3'b000;
    localparam int         MULT_ITERS = 32;
    localparam int         CNT_W      = $clog2(MULT_ITERS) + 1;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_LAST = cnt_t'(MULT_ITERS - 1);

    // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned 2^31.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mult_sequencer.sv
// 32x32 shift-add multiplier borrowing the shared ALU adder; start-to-done latency 34 cycles.
// Backpressure: StallMult holds the pipeline through ITER and SIGN; starts are ignored while busy.
module mult_sequencer
    import mult_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        MultStartE,
    input  logic        MultSgnE,
    input  logic        FlushE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic [31:0] ALUOut,
    output logic        ALUSel,
    output logic [31:0] ALU_A,
    output logic [31:0] ALU_B,
    output logic [2:0]  ALUF,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        StallMult,
    output logic        completed
);

    state_t      state_q,  state_d;
    logic [31:0] mcand_q,  mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic [31:0] hi_q,     hi_d;
    logic [31:0] lo_q,     lo_d;
    cnt_t        count_q,  count_d;
    logic        neg_q,    neg_d;

    logic [31:0] addend;
    logic        carry;
    logic [63:0] prod;
    logic [63:0] prod_signed;

    // The ALU only returns a 32-bit sum, so the carry out is rebuilt from the operand MSBs.
    assign addend      = mplier_q[0] ? mcand_q : 32'd0;
    assign carry       = (acc_hi_q[31] & addend[31]) |
                         ((acc_hi_q[31] | addend[31]) & ~ALUOut[31]);
    assign prod        = {acc_hi_q, acc_lo_q};
    assign prod_signed = neg_q ? (~prod + 64'd1) : prod;

    assign hi = hi_q;
    assign lo = lo_q;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        count_d   = count_q;
        neg_d     = neg_q;
        ALUSel    = 1'b0;
        ALU_A     = 32'd0;
        ALU_B     = 32'd0;
        ALUF      = ALU_NONE;
        StallMult = 1'b0;
        completed = 1'b0;

        case (state_q)
            IDLE: begin
                if (MultStartE && !FlushE) begin
                    mcand_d  = MultSgnE ? mag32(SrcAE) : SrcAE;
                    mplier_d = MultSgnE ? mag32(SrcBE) : SrcBE;
                    neg_d    = MultSgnE & (SrcAE[31] ^ SrcBE[31]);
                    acc_hi_d = 32'd0;
                    acc_lo_d = 32'd0;
                    count_d  = '0;
                    state_d  = ITER;
                end
            end
            ITER: begin
                ALUSel    = 1'b1;
                ALU_A     = acc_hi_q;
                ALU_B     = addend;
                ALUF      = ALU_ADD;
                StallMult = 1'b1;
                if (FlushE) begin
                    state_d = IDLE;
                end else begin
                    acc_hi_d = {carry, ALUOut[31:1]};
                    acc_lo_d = {ALUOut[0], acc_lo_q[31:1]};
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + cnt_t'(1);
                    if (count_q == CNT_LAST) begin
                        state_d = SIGN;
                    end
                end
            end
            SIGN: begin
                StallMult = 1'b1;
                if (FlushE) begin
                    state_d = IDLE;
                end else begin
                    hi_d    = prod_signed[63:32];
                    lo_d    = prod_signed[31:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                // A flush here is too late to matter: the result is already committed.
                completed = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            acc_hi_q <= 32'd0;
            acc_lo_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            count_q  <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            count_q  <= count_d;
            neg_q    <= neg_d;
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed and randomized checks of mult_sequencer against an arithmetic product model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mult_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        MultStartE;
    logic        MultSgnE;
    logic        FlushE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic [31:0] ALUOut;
    logic        ALUSel;
    logic [31:0] ALU_A;
    logic [31:0] ALU_B;
    logic [2:0]  ALUF;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        StallMult;
    logic        completed;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Shared ALU stand-in: adds only when the sequencer owns it and requests ADD.
    assign ALUOut = (ALUSel && ALUF == 3'b010) ? (ALU_A + ALU_B) : (SrcAE ^ SrcBE);

    mult_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .MultStartE (MultStartE),
        .MultSgnE   (MultSgnE),
        .FlushE     (FlushE),
        .SrcAE      (SrcAE),
        .SrcBE      (SrcBE),
        .ALUOut     (ALUOut),
        .ALUSel     (ALUSel),
        .ALU_A      (ALU_A),
        .ALU_B      (ALU_B),
        .ALUF       (ALUF),
        .hi         (hi),
        .lo         (lo),
        .StallMult  (StallMult),
        .completed  (completed)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL #%0d %s: observed %h expected %h", n_fail, tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alusel"}, 64'(ALUSel), 64'd0);
        check({tag, "_alu_a"}, 64'(ALU_A), 64'd0);
        check({tag, "_alu_b"}, 64'(ALU_B), 64'd0);
        check({tag, "_aluf"}, 64'(ALUF), 64'd0);
        check({tag, "_hilo"}, {hi, lo}, 64'd0);
        check({tag, "_stall"}, 64'(StallMult), 64'd0);
        check({tag, "_completed"}, 64'(completed), 64'd0);
    endtask

    function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b,
                                               input logic sgn);
        longint sa, sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Called at a falling edge; returns at the falling edge after the block is idle again.
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                            input logic poke, input string tag);
        logic [63:0] exp;
        logic [63:0] old;
        logic [31:0] ma;
        logic [31:0] mb;
        int          stall_cnt;
        int          done_at;
        int          alu_bad;
        exp       = model_prod(a, b, sgn);
        ma        = (sgn && a[31]) ? (32'd0 - a) : a;
        mb        = (sgn && b[31]) ? (32'd0 - b) : b;
        old       = {hi, lo};
        stall_cnt = 0;
        done_at   = -1;
        alu_bad   = 0;
        SrcAE      = a;
        SrcBE      = b;
        MultSgnE   = sgn;
        MultStartE = 1'b1;
        for (int s = 0; s < 36; s++) begin
            @(negedge clk);
            if (s == 0) begin
                MultStartE = 1'b0;
                SrcAE      = $urandom;
                SrcBE      = $urandom;
                MultSgnE   = ~sgn;
            end
            if (poke && s == 5) MultStartE = 1'b1;
            if (s == 6) MultStartE = 1'b0;
            if (StallMult) stall_cnt++;
            if (completed) done_at = (done_at < 0) ? s : 99;
            if (s < 32) begin
                if (ALUSel !== 1'b1 || ALUF !== 3'b010 || ALU_B !== (mb[s] ? ma : 32'd0))
                    alu_bad++;
            end else if (ALUSel !== 1'b0 || ALU_A !== 32'd0 || ALU_B !== 32'd0 ||
                         ALUF !== 3'b000) begin
                alu_bad++;
            end
            if (s == 32) check({tag, "_hilo_hold"}, {hi, lo}, old);
            if (s == 33) check({tag, "_stall_in_done"}, 64'(StallMult), 64'd0);
        end
        check({tag, "_product"}, {hi, lo}, exp);
        check({tag, "_stall_cycles"}, 64'(stall_cnt), 64'd33);
        check({tag, "_done_cycle"}, 64'(done_at), 64'd33);
        check({tag, "_alu_drive"}, 64'(alu_bad), 64'd0);
    endtask

    // Unsigned multiply with a one-cycle flush raised at cycle flush_s after the start edge.
    task automatic flush_run(input logic [31:0] a, input logic [31:0] b, input int flush_s,
                             input logic expect_done, input string tag);
        logic [63:0] exp;
        int          dones;
        exp   = expect_done ? ({32'd0, a} * {32'd0, b}) : {hi, lo};
        dones = 0;
        SrcAE      = a;
        SrcBE      = b;
        MultSgnE   = 1'b0;
        MultStartE = 1'b1;
        for (int s = 0; s < 40; s++) begin
            @(negedge clk);
            if (s == 0) MultStartE = 1'b0;
            if (completed) dones++;
            if (s == flush_s) FlushE = 1'b1;
            if (s == flush_s + 1) begin
                FlushE = 1'b0;
                check({tag, "_idle_after"}, {63'd0, ALUSel | StallMult}, 64'd0);
            end
        end
        check({tag, "_done_pulses"}, 64'(dones), expect_done ? 64'd1 : 64'd0);
        check({tag, "_hilo"}, {hi, lo}, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        MultStartE = 1'b0;
        MultSgnE   = 1'b0;
        FlushE     = 1'b0;
        SrcAE      = 32'd0;
        SrcBE      = 32'd0;
        @(negedge clk);
        check_all_zero("reset");

        // Start is presented so the first edge after release accepts it.
        rst = 1'b0;
        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "umax");
        check("umax_hi", 64'(hi), 64'hFFFF_FFFE);
        check("umax_lo", 64'(lo), 64'h0000_0001);

        run_mult(32'hFFFF_FFFD, 32'd7, 1'b1, 1'b1, "neg3x7");
        check("neg3x7_lo", 64'(lo), 64'hFFFF_FFEB);
        run_mult(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, "smin_sq");
        run_mult(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, "umin_sq");
        check("min_sq_hi", 64'(hi), 64'h4000_0000);
        run_mult(32'd0, 32'hFFFF_FFF9, 1'b1, 1'b0, "zero_neg");
        run_mult(32'h8000_0000, 32'd1, 1'b1, 1'b0, "smin_x1");

        run_mult(32'd5, 32'd6, 1'b0, 1'b0, "five_six");
        flush_run(32'd9, 32'd9, 10, 1'b0, "flush_iter");
        check("flush_iter_lo30", 64'(lo), 64'd30);
        flush_run(32'd9, 32'd9, 32, 1'b0, "flush_sign");
        flush_run(32'd9, 32'd9, 33, 1'b1, "flush_done");

        SrcAE      = 32'h1234_5678;
        SrcBE      = 32'h9ABC_DEF1;
        MultSgnE   = 1'b0;
        MultStartE = 1'b1;
        for (int s = 0; s <= 20; s++) begin
            @(negedge clk);
            if (s == 0) MultStartE = 1'b0;
        end
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        run_mult(32'd2, 32'd3, 1'b0, 1'b0, "after_reset");

        for (int i = 0; i < 12; i++) begin
            run_mult($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
